// File: rtl/iccm_boot_loader_pkg.sv
// Shared types and constants for the UART-to-ICCM boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM
  } boot_state_e;

  localparam logic [7:0] BOOT_SYNC_DEFAULT = 8'hA5;

  // Width of a counter that must be able to hold the value 'cycles'.
  function automatic int unsigned timeout_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/iccm_boot_loader_packer.sv
// Packs little-endian payload bytes into 32-bit words; word strobe is combinational with the 4th byte.
module boot_word_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_dv,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_idx;
  logic [31:0] shreg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      shreg    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      shreg    <= '0;
    end else if (byte_dv) begin
      byte_idx <= byte_idx + 2'd1;
      shreg    <= {byte_in, shreg[31:8]};
    end
  end

  // Newest byte lands in the top lane, so after four bytes lane 0 holds the first one.
  assign word       = {byte_in, shreg[31:8]};
  assign word_valid = byte_dv && (byte_idx == 2'd3);

endmodule

// File: rtl/iccm_boot_loader.sv
// Framed UART boot loader: sync, 16-bit word count, payload, checksum -> ICCM word writes.
module iccm_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned AddrW         = 12,
  parameter logic [7:0]  SyncByte      = BOOT_SYNC_DEFAULT,
  parameter int unsigned TimeoutCycles = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_dv_i,
  input  logic [7:0]       rx_byte_i,
  output logic             we_o,
  output logic [AddrW-1:0] addr_o,
  output logic [31:0]      wdata_o,
  output logic             core_hold_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned         TimeoutW   = timeout_width(TimeoutCycles);
  localparam logic [TimeoutW-1:0] TimeoutMax = TimeoutW'(TimeoutCycles);
  localparam logic [31:0]         MaxWords   = 32'(1) << AddrW;

  boot_state_e         state;
  logic [7:0]          len_lo;
  logic [15:0]         len_full;
  logic [15:0]         remaining;
  logic [7:0]          csum;
  logic [AddrW-1:0]    addr_cnt;
  logic [TimeoutW-1:0] tcnt;

  logic        sync_seen;
  logic        pk_dv;
  logic        pk_valid;
  logic [31:0] pk_word;

  assign len_full  = {rx_byte_i, len_lo};
  assign sync_seen = rx_dv_i && (state == IDLE) && (rx_byte_i == SyncByte);
  assign pk_dv     = rx_dv_i && (state == DATA);

  boot_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (sync_seen),
    .byte_dv    (pk_dv),
    .byte_in    (rx_byte_i),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      len_lo      <= '0;
      remaining   <= '0;
      csum        <= '0;
      addr_cnt    <= '0;
      tcnt        <= '0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      core_hold_o <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      we_o   <= 1'b0;
      done_o <= 1'b0;

      // Timeout only acts on idle cycles, so it never competes with byte handling below.
      if (state != IDLE) begin
        if (rx_dv_i) begin
          tcnt <= '0;
        end else if (tcnt == TimeoutMax - TimeoutW'(1)) begin
          tcnt  <= '0;
          err_o <= 1'b1;
          state <= IDLE;
        end else begin
          tcnt <= tcnt + TimeoutW'(1);
        end
      end

      if (rx_dv_i) begin
        unique case (state)
          IDLE: begin
            if (rx_byte_i == SyncByte) begin
              state       <= LEN_LO;
              core_hold_o <= 1'b1;
              err_o       <= 1'b0;
              addr_cnt    <= '0;
              csum        <= '0;
              tcnt        <= '0;
            end
          end
          LEN_LO: begin
            len_lo <= rx_byte_i;
            state  <= LEN_HI;
          end
          LEN_HI: begin
            if ({16'd0, len_full} > MaxWords) begin
              err_o <= 1'b1;
              state <= IDLE;
            end else if (len_full == 16'd0) begin
              state <= CSUM;
            end else begin
              remaining <= len_full;
              state     <= DATA;
            end
          end
          DATA: begin
            csum <= csum + rx_byte_i;
            if (pk_valid) begin
              we_o      <= 1'b1;
              addr_o    <= addr_cnt;
              wdata_o   <= pk_word;
              addr_cnt  <= addr_cnt + AddrW'(1);
              remaining <= remaining - 16'd1;
              if (remaining == 16'd1) state <= CSUM;
            end
          end
          CSUM: begin
            if (rx_byte_i == csum) begin
              done_o      <= 1'b1;
              core_hold_o <= 1'b0;
            end else begin
              err_o <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
